// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the execute stage and the load/store unit.
// The master issues load/store requests; the slave returns pipelined responses.
interface data_memory_lsu_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;
  logic        access_fault;

  modport master (
    output req_valid, req_write, req_funct3, addr, write_data,
    input  resp_valid, read_data, misaligned, access_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, addr, write_data,
    output resp_valid, read_data, misaligned, access_fault
  );
endinterface

// File: rtl/data_memory_lsu.sv
// RV32I data memory with byte-lane stores, extended loads, fault flags and a
// valid-tagged response pipeline of configurable depth.
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  data_memory_lsu_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          legal;
  logic          mis_raw;
  logic          fault;
  logic          mis;
  logic          clean;
  logic          do_write;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [31:0]   resp_data;

  logic [31:0] mem [DEPTH_WORDS];

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] mis_q;
  logic [READ_LATENCY-1:0] flt_q;
  logic [31:0]             data_q [READ_LATENCY];

  // BASE_ADDR is aligned to the memory size, so off[1:0] equals addr[1:0].
  assign off      = bus.addr - BASE_ADDR;
  assign in_range = (off[31:AW+2] == '0);
  assign word_idx = off[AW+1:2];
  assign lane     = off[1:0];

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_write;
      default:                legal = 1'b0;
    endcase
    mis_raw = ((bus.req_funct3[1:0] == 2'b01) && lane[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    fault = !legal || !in_range;
    mis   = legal && mis_raw;
    clean = !fault && !mis;
  end

  always_comb begin
    byte_en = 4'b1111;
    wr_word = bus.write_data;
    case (bus.req_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.write_data[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_word = bus.write_data;
      end
    endcase
  end

  // Gating with reset_n keeps a store that lands on a reset edge from writing.
  assign do_write = bus.req_valid && bus.req_write && clean && reset_n;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = 8'(rd_word >> {lane, 3'b000});
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (bus.req_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = '0;
    endcase
    resp_data = (bus.req_write || !clean) ? 32'h0 : load_val;
  end

  // Idle stages carry zeros so the outputs are quiet whenever resp_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      mis_q <= '0;
      flt_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= bus.req_valid;
      mis_q[0]  <= bus.req_valid && mis;
      flt_q[0]  <= bus.req_valid && fault;
      data_q[0] <= bus.req_valid ? resp_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        mis_q[i]  <= mis_q[i-1];
        flt_q[i]  <= flt_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.resp_valid   = vld_q[READ_LATENCY-1];
  assign bus.misaligned   = mis_q[READ_LATENCY-1];
  assign bus.access_fault = flt_q[READ_LATENCY-1];
  assign bus.read_data    = data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_lsu.sv
// Drives identical request streams into a latency-1 and a latency-3 instance
// and compares both against a byte-array reference model every cycle.
module tb_data_memory_lsu;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          MAXC  = 4096;
  localparam bit [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        mis;
    logic        flt;
  } resp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  data_memory_lsu_if bus1 ();
  data_memory_lsu_if bus3 ();

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );
  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] model_mem [DEPTH*4];
  resp_t      hist [MAXC];
  int         edge_n       = 0;
  int         n_compared   = 0;
  int         n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference: address arithmetic on a flat byte array, extension by subtraction.
  task automatic model_access(input bit w, input bit [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output resp_t r);
    int     size;
    bit     legal;
    longint off;
    longint val;
    r   = '0;
    r.v = 1'b1;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) begin
      r.flt = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
    off  = longint'(a) - longint'(BASE);
    if (off < 0 || off >= longint'(DEPTH * 4)) r.flt = 1'b1;
    if ((a % size) != 0) r.mis = 1'b1;
    if (r.flt || r.mis) return;
    if (w) begin
      for (int k = 0; k < size; k++) model_mem[int'(off) + k] = wd[8*k +: 8];
    end else begin
      val = 0;
      for (int k = 0; k < size; k++) val = val + (longint'(model_mem[int'(off) + k]) << (8 * k));
      if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val = val - (longint'(1) << (8 * size));
      r.d = 32'(val);
    end
  endtask

  task automatic drive(input bit v, input bit w, input bit [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus1.req_valid = v;  bus1.req_write = w;  bus1.req_funct3 = f3;
    bus1.addr      = a;  bus1.write_data = wd;
    bus3.req_valid = v;  bus3.req_write = w;  bus3.req_funct3 = f3;
    bus3.addr      = a;  bus3.write_data = wd;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < MAXC; i++) hist[i] = '0;
  endtask

  task automatic tick();
    resp_t e1;
    resp_t e3;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    e1 = hist[edge_n];
    e3 = (edge_n >= 2) ? hist[edge_n - 2] : '0;
    checkOutput("L1 resp_valid",   32'(bus1.resp_valid),   32'(e1.v));
    checkOutput("L1 read_data",    bus1.read_data,         e1.d);
    checkOutput("L1 misaligned",   32'(bus1.misaligned),   32'(e1.mis));
    checkOutput("L1 access_fault", 32'(bus1.access_fault), 32'(e1.flt));
    checkOutput("L3 resp_valid",   32'(bus3.resp_valid),   32'(e3.v));
    checkOutput("L3 read_data",    bus3.read_data,         e3.d);
    checkOutput("L3 misaligned",   32'(bus3.misaligned),   32'(e3.mis));
    checkOutput("L3 access_fault", 32'(bus3.access_fault), 32'(e3.flt));
  endtask

  task automatic applyStimulus(input bit v, input bit w, input bit [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    resp_t r;
    drive(v, w, f3, a, wd);
    r = '0;
    if (v) model_access(w, f3, a, wd, r);
    if (edge_n + 1 >= MAXC) begin
      $display("[TB] FAIL history: edge %0d, limit %0d", edge_n, MAXC);
      $fatal(1, "[TB] history exhausted");
    end
    hist[edge_n + 1] = r;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // Outputs must drop as soon as reset_n falls; in-flight responses vanish.
  task automatic do_reset();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst L1 resp_valid",   32'(bus1.resp_valid),   32'h0);
    checkOutput("rst L1 read_data",    bus1.read_data,         32'h0);
    checkOutput("rst L1 misaligned",   32'(bus1.misaligned),   32'h0);
    checkOutput("rst L1 access_fault", 32'(bus1.access_fault), 32'h0);
    checkOutput("rst L3 resp_valid",   32'(bus3.resp_valid),   32'h0);
    checkOutput("rst L3 read_data",    bus3.read_data,         32'h0);
    checkOutput("rst L3 misaligned",   32'(bus3.misaligned),   32'h0);
    checkOutput("rst L3 access_fault", 32'(bus3.access_fault), 32'h0);
    clear_hist();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bit          v;
    bit          w;
    bit [2:0]    f3;
    logic [31:0] a;
    clear_hist();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    do_reset();

    $display("[TB] preload all words with zero");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, F_W, BASE + 32'(4 * i), 32'h0);

    $display("[TB] basic store/load");
    applyStimulus(1, 1, F_W, BASE + 32'h10, 32'hF0F0_F0F0);
    applyStimulus(1, 0, F_W, BASE + 32'h10, 32'h0);
    idle(3);

    $display("[TB] byte lanes");
    applyStimulus(1, 1, F_W,  BASE + 32'h20, 32'h0);
    applyStimulus(1, 1, F_B,  BASE + 32'h21, 32'h0000_0080);
    applyStimulus(1, 0, F_B,  BASE + 32'h21, 32'h0);
    applyStimulus(1, 0, F_BU, BASE + 32'h21, 32'h0);
    applyStimulus(1, 0, F_W,  BASE + 32'h20, 32'h0);
    applyStimulus(1, 1, F_H,  BASE + 32'h22, 32'h0000_BEEF);
    applyStimulus(1, 0, F_W,  BASE + 32'h20, 32'h0);
    applyStimulus(1, 0, F_H,  BASE + 32'h22, 32'h0);
    applyStimulus(1, 0, F_HU, BASE + 32'h22, 32'h0);
    idle(3);

    $display("[TB] faults");
    applyStimulus(1, 0, F_W,  BASE + 32'h11, 32'h0);
    applyStimulus(1, 1, F_H,  BASE + 32'h13, 32'h1234_5678);
    applyStimulus(1, 0, F_W,  BASE + 32'h10, 32'h0);
    applyStimulus(1, 0, F_W,  BASE + 32'(DEPTH * 4), 32'h0);
    applyStimulus(1, 0, F_W,  BASE + 32'(DEPTH * 4) + 32'h2, 32'h0);
    applyStimulus(1, 0, F_W,  BASE - 32'h4, 32'h0);
    applyStimulus(1, 1, F_W,  BASE + 32'(DEPTH * 4), 32'hDEAD_BEEF);
    applyStimulus(1, 0, 3'b011, BASE + 32'h10, 32'h0);
    applyStimulus(1, 1, 3'b011, BASE + 32'h11, 32'h0);
    applyStimulus(1, 1, F_BU, BASE + 32'h10, 32'hFFFF_FFFF);
    applyStimulus(1, 0, F_W,  BASE + 32'h10, 32'h0);
    idle(3);

    $display("[TB] back-to-back");
    applyStimulus(1, 1, F_W,  BASE + 32'h40, 32'hA5A5_A5A5);
    applyStimulus(1, 0, F_W,  BASE + 32'h40, 32'h0);
    applyStimulus(1, 0, F_W,  BASE + 32'h44, 32'h0);
    applyStimulus(1, 0, F_BU, BASE + 32'h40, 32'h0);
    idle(3);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 0, F_W, BASE + 32'h10, 32'h0);
    applyStimulus(1, 0, F_W, BASE + 32'h20, 32'h0);
    applyStimulus(1, 0, F_W, BASE + 32'h40, 32'h0);
    do_reset();
    idle(3);
    applyStimulus(1, 0, F_W, BASE + 32'h10, 32'h0);
    applyStimulus(1, 0, F_W, BASE + 32'h20, 32'h0);
    applyStimulus(1, 0, F_W, BASE + 32'h40, 32'h0);
    idle(3);

    $display("[TB] sweep");
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        applyStimulus(1, 1, F_W, BASE + 32'(4 * i), (p == 0) ? 32'hF0F0_F0F0 : 32'h0F0F_0F0F);
        applyStimulus(1, 0, F_W, BASE + 32'(4 * i), 32'h0);
      end
    end
    idle(3);

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      v = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       f3 = 3'($urandom_range(0, 7));
        1, 2:    f3 = F_W;
        3:       f3 = F_H;
        4:       f3 = F_B;
        5:       f3 = F_HU;
        default: f3 = F_BU;
      endcase
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      applyStimulus(v, w, f3, a, $urandom);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
